vector_sequencer: RTL
=====================

# vector_sequencer

Instruction sequencer for `vector_processor`. It accepts packed vector instructions over a valid/ready port into a small FIFO. It issues them one at a time onto the processor's `op_code`/register/memory-address inputs and holds each instruction for its execution latency before issuing the next. This serialises the A1/A2 → A3/A4 datapath, so a store of A3 never overtakes the add/multiply that produces it.

## Interface
- `DEPTH`, 4: instruction FIFO entries; power of 2, ≥ 2.
- `LDST_CYCLES`, 1: cycles an op `00` (load) or op `01` (store) is held; ≥ 1.
- `ADD_CYCLES`, 1: cycles an op `10` (add) is held; ≥ 1.
- `MUL_CYCLES`, 2: cycles an op `11` (multiply) is held; ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `instr_valid` in 1: `instr_data` is valid.
- `instr_ready` out 1: FIFO can accept an instruction.
- `instr_data` in 15: instruction word.
  - [14:13] op.
  - [12:11] write reg.
  - [10:9] read reg.
  - [8:0] mem addr.
- `op_code` out 2: to processor.
- `reg_addr_to_write` out 2: to processor.
- `reg_addr_to_read` out 2: to processor.
- `mem_addr` out 9: to processor.
- `busy` out 1: state EXEC or FIFO non-empty.
- `retire` out 1: the issued instruction is in its last held cycle.
- `retired_count` out 16: instructions retired since reset; wraps.

## Operation
- FIFO behaviour:
  - Push occurs when `instr_valid && instr_ready`.
  - `instr_ready` = (count < DEPTH), registered state only.
  - When full, `instr_ready` is low even if a pop occurs in the same cycle. There is no same-cycle bypass.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- State machine (two states: IDLE, EXEC). `cnt` is the latency down-counter, 8 bits.
  - IDLE, FIFO empty: stay in IDLE; outputs hold their last values.
  - IDLE, FIFO non-empty: pop the head; load the four processor outputs from the head fields; load `cnt` = latency(op) − 1; go to EXEC.
  - EXEC, `cnt` ≠ 0: decrement `cnt`; outputs hold.
  - EXEC, `cnt` = 0, FIFO non-empty: issue the next instruction back-to-back (pop, load outputs, reload `cnt`); stay in EXEC.
  - EXEC, `cnt` = 0, FIFO empty: go to IDLE; outputs hold.
- Latency by op: `00`, `01` → LDST_CYCLES; `10` → ADD_CYCLES; `11` → MUL_CYCLES.
- `retire` = (state == EXEC && cnt == 0).
- `retired_count` increments by 1 in every cycle where `retire` is high; it wraps from 0xFFFF to 0.
- Holding outputs in IDLE re-executes the last instruction. This is idempotent for all four ops and is the intended idle behaviour; the processor has no enable.
- All four op encodings are legal. Field contents are not checked.
- Reset (asynchronous, mid-operation included) forces:
  - FIFO empty; state IDLE; `cnt` = 0; `retired_count` = 0.
  - `op_code`, `reg_addr_to_write`, `reg_addr_to_read`, `mem_addr` = 0.
  - `retire` = 0; `busy` = 0; `instr_ready` = 1.
  - Any in-flight or queued instruction is discarded.

## Timing
- Instruction accepted at edge N → outputs change at edge N+1 (when the sequencer was idle).
- An op with latency L is driven for exactly L cycles; `retire` is high in the L-th cycle.
- Back-to-back issue: the next instruction's outputs appear at the edge immediately after the retire cycle, with no bubble.
- Pop and push in the same cycle are allowed when not full; count is unchanged.
- `busy` falls in the cycle after the final `retire` when no instruction is queued.

## Test plan
- **Reset values:** assert `rst`=0 mid-stream → all outputs 0 and `instr_ready`=1 immediately, without waiting for a clock edge. Release → state IDLE, `retired_count`=0.
- **Single load:** push {00, 01, xx, 0x010} at edge N → at edge N+1, `op_code`=00, `reg_addr_to_write`=1, `mem_addr`=16. `retire`=1 for one cycle; `busy` low one cycle later.
- **Mul then store:** push {11, …} then {01, read 2, 0x020} → `op_code`=11 for exactly 2 cycles, then `op_code`=01 with `mem_addr`=32 for 1 cycle. `retire` pulses twice; `retired_count`=2.
- **FIFO full, DEPTH=4:** during a MUL, push 5 instructions with `instr_valid` held high → `instr_ready` goes low after the 4th accept. The 5th is accepted only after the next pop. Issue order and all fields are preserved.
- **Reset mid-multiply:** assert reset in the 1st MUL cycle with 3 instructions queued → no further issues after release. `retired_count`=0; outputs 0.
- **Idle hold and counter wrap:** after the last retire, outputs stay at the last instruction's values for 10 idle cycles. With `retired_count` preloaded by 65535 retirements, one more retire → 0.

Source files
------------

// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vector_sequencer
//  Function : Queues packed vector instructions and issues them one at a time,
//             holding each on the processor inputs for its execution latency.
//  Revision : 1.0
// ============================================================================

module vector_sequencer #(
    parameter int DEPTH       = 4,
    parameter int LDST_CYCLES = 1,
    parameter int ADD_CYCLES  = 1,
    parameter int MUL_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [14:0] instr_data,
    output logic [1:0]  op_code,
    output logic [1:0]  reg_addr_to_write,
    output logic [1:0]  reg_addr_to_read,
    output logic [8:0]  mem_addr,
    output logic        busy,
    output logic        retire,
    output logic [15:0] retired_count
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    localparam logic [7:0] C_LAT_LDST = 8'(LDST_CYCLES - 1);
    localparam logic [7:0] C_LAT_ADD  = 8'(ADD_CYCLES - 1);
    localparam logic [7:0] C_LAT_MUL  = 8'(MUL_CYCLES - 1);

    localparam logic [0:0] C_S_IDLE = 1'b0;
    localparam logic [0:0] C_S_EXEC = 1'b1;

    logic [14:0]        r_fifo [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [7:0]         r_cnt;

    logic [14:0]        w_head;
    logic [7:0]         w_head_lat;
    logic               w_empty;
    logic               w_push;
    logic               w_issue;
    logic               w_retire;
    logic               w_busy;

    // ------------------------------------------------------------------
    // Instruction FIFO. Readiness depends on registered occupancy only,
    // so a full FIFO stays not-ready even in a cycle that pops.
    // ------------------------------------------------------------------
    assign w_empty     = (r_count == '0);
    assign instr_ready = (r_count < C_CNT_W'(DEPTH));
    assign w_push      = instr_valid && instr_ready;
    assign w_head      = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= instr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_head_lat = C_LAT_LDST;
        case (w_head[14:13])
            2'b10:   w_head_lat = C_LAT_ADD;
            2'b11:   w_head_lat = C_LAT_MUL;
            default: w_head_lat = C_LAT_LDST;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= C_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = C_S_EXEC;
                end
            end
            C_S_EXEC: begin
                if (r_cnt == 8'd0 && w_empty) begin
                    w_state_nxt = C_S_IDLE;
                end
            end
            default: w_state_nxt = C_S_IDLE;
        endcase
    end

    always_comb begin
        w_issue  = 1'b0;
        w_retire = 1'b0;
        w_busy   = !w_empty;
        case (r_state)
            C_S_IDLE: begin
                w_issue = !w_empty;
            end
            C_S_EXEC: begin
                w_retire = (r_cnt == 8'd0);
                w_issue  = (r_cnt == 8'd0) && !w_empty;
                w_busy   = 1'b1;
            end
            default: begin
                w_issue  = 1'b0;
                w_retire = 1'b0;
            end
        endcase
    end

    assign retire = w_retire;
    assign busy   = w_busy;

    // ------------------------------------------------------------------
    // Processor-facing registers. Outside an issue they simply hold, which
    // re-executes the last instruction harmlessly while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_code           <= '0;
            reg_addr_to_write <= '0;
            reg_addr_to_read  <= '0;
            mem_addr          <= '0;
            r_cnt             <= '0;
        end else if (w_issue) begin
            op_code           <= w_head[14:13];
            reg_addr_to_write <= w_head[12:11];
            reg_addr_to_read  <= w_head[10:9];
            mem_addr          <= w_head[8:0];
            r_cnt             <= w_head_lat;
        end else if (r_state == C_S_EXEC && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_count <= '0;
        end else if (w_retire) begin
            retired_count <= retired_count + 16'd1;
        end
    end

endmodule

`default_nettype wire
